axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master_if.sv | 29 ++
 rtl/axi_lite_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite write/read channel bundle between one master and its slave.
interface axi_lite_master_if;
   logic [3:0]  AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into bus handshakes and
// returns one registered response, with an optional bus-wait timeout.
module axi_lite_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [3:0]        cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              rsp_timeout,
   axi_lite_master_if.master axi
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   logic [2:0]  state_q, state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  rsp_resp_q, rsp_resp_d;
   logic [3:0]  awaddr_q, awaddr_d;
   logic [3:0]  araddr_q, araddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [15:0] cnt_q, cnt_d;

   logic [15:0] cnt_inc;
   logic        timeout_hit;
   logic        to_fire;
   logic        aw_hs, w_hs;

   assign aw_hs = awvalid_q && axi.AWREADY;
   assign w_hs  = wvalid_q && axi.WREADY;

   // Saturating increment; >= keeps a saturated counter from missing the limit.
   assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_inc) >= TIMEOUT_CYCLES);

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      awaddr_d      = awaddr_q;
      araddr_d      = araddr_q;
      wdata_d       = wdata_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      cnt_d         = cnt_q;
      to_fire       = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               cnt_d       = 16'd0;
               awaddr_d    = cmd_addr;
               araddr_d    = cmd_addr;
               wdata_d     = cmd_wdata;
               if (cmd_write) begin
                  state_d   = S_WADDR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = S_RADDR;
                  arvalid_d = 1'b1;
               end
            end
         end

         S_WADDR: begin
            cnt_d = cnt_inc;
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = S_WRESP;
               bready_d = 1'b1;
            end else if (timeout_hit) begin
               to_fire = 1'b1;
            end
         end

         S_WRESP: begin
            cnt_d = cnt_inc;
            if (bready_q && axi.BVALID) begin
               state_d       = S_RESP;
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               rsp_resp_d    = axi.BRESP;
               rsp_rdata_d   = 32'd0;
            end else if (timeout_hit) begin
               to_fire = 1'b1;
            end
         end

         S_RADDR: begin
            cnt_d = cnt_inc;
            if (arvalid_q && axi.ARREADY) begin
               state_d   = S_RDATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end else if (timeout_hit) begin
               to_fire = 1'b1;
            end
         end

         S_RDATA: begin
            cnt_d = cnt_inc;
            if (rready_q && axi.RVALID) begin
               state_d       = S_RESP;
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               rsp_resp_d    = axi.RRESP;
               rsp_rdata_d   = axi.RDATA;
            end else if (timeout_hit) begin
               to_fire = 1'b1;
            end
         end

         S_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abandon the bus entirely; late B/R beats then meet BREADY/RREADY low.
      if (to_fire) begin
         state_d       = S_RESP;
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_timeout_d = 1'b1;
         rsp_resp_d    = 2'b10;
         rsp_rdata_d   = 32'd0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q       <= S_IDLE;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= 32'd0;
         rsp_resp_q    <= 2'b00;
         awaddr_q      <= 4'd0;
         araddr_q      <= 4'd0;
         wdata_q       <= 32'd0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         cnt_q         <= 16'd0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         awaddr_q      <= awaddr_d;
         araddr_q      <= araddr_d;
         wdata_q       <= wdata_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign axi.AWADDR  = awaddr_q;
   assign axi.AWVALID = awvalid_q;
   assign axi.WDATA   = wdata_q;
   assign axi.WVALID  = wvalid_q;
   assign axi.BREADY  = bready_q;
   assign axi.ARADDR  = araddr_q;
   assign axi.ARVALID = arvalid_q;
   assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural memory slave with programmable ready/valid
// delays, plus a response scoreboard fed when each command is issued.
`timescale 1ns/1ps
module tb_axi_lite_master;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axi_lite_master_if bus ();

   axi_lite_master #(.TIMEOUT_CYCLES(8)) dut (
      .ACLK        (ACLK),
      .ARESETn     (ARESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .rsp_timeout (rsp_timeout),
      .axi         (bus)
   );

   initial forever #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        to;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem[16];
   logic [31:0] mem[16];
   int          n_total = 0;
   int          n_bad = 0;
   int          n_rsp = 0;

   int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
   logic [1:0]  bresp_cfg, rresp_cfg;
   bit          ar_never, stray;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic t);
      exp_t e;
      e.rdata = d;
      e.resp  = r;
      e.to    = t;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                           output int waited);
      bit ok = 1'b0;
      waited = 0;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge ACLK);
         ok = cmd_ready;
         if (!ok) waited++;
         @(posedge ACLK);
         #1;
      end
      cmd_valid = 1'b0;
      if (!ok) check("cmd_accept", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input int target);
      int i = 0;
      while (n_rsp < target && i < 100) begin
         @(posedge ACLK);
         #1;
         i++;
      end
      if (n_rsp < target) check("rsp_wait", 32'(n_rsp), 32'(target));
      else check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
   endtask

   // Slave: decides READY/VALID at each negedge; *_hs flags mark the handshakes
   // that the following posedge will complete.
   initial begin : slave
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, b_wait, r_wait, stray_q;
      logic [3:0]  aw_addr_s, ar_addr_s;
      logic [31:0] w_data_s;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0; stray_q = 0;
      aw_addr_s = '0; ar_addr_s = '0; w_data_s = '0;
      bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
      bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESETn) begin
            bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0;
            bus.ARREADY = 0; bus.RVALID = 0;
            aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
            aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
         end else begin
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got) begin
               mem[aw_addr_s] = w_data_s;
               aw_got = 0; w_got = 0; b_wait = 1; b_cnt = 0;
            end
            if (b_hs) bus.BVALID = 0;
            if (b_wait) begin
               if (b_cnt >= b_dly) begin
                  bus.BVALID = 1; bus.BRESP = bresp_cfg; b_wait = 0;
               end else b_cnt++;
            end
            if (r_hs) bus.RVALID = 0;
            if (ar_hs) begin r_wait = 1; r_cnt = 0; end
            if (r_wait) begin
               if (r_cnt >= r_dly) begin
                  bus.RVALID = 1; bus.RDATA = mem[ar_addr_s]; bus.RRESP = rresp_cfg;
                  r_wait = 0;
               end else r_cnt++;
            end
            if (bus.AWVALID) begin bus.AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin bus.AWREADY = 0; aw_cnt = 0; end
            if (bus.WVALID) begin bus.WREADY = (w_cnt >= w_dly); w_cnt++; end
            else begin bus.WREADY = 0; w_cnt = 0; end
            if (bus.ARVALID) begin bus.ARREADY = !ar_never && (ar_cnt >= ar_dly); ar_cnt++; end
            else begin bus.ARREADY = 0; ar_cnt = 0; end
            if (stray) begin
               bus.BVALID = 1; bus.RVALID = 1; bus.RDATA = 32'hBAD0BAD0; bus.BRESP = 2'b11;
            end else if (stray_q) begin
               bus.BVALID = 0; bus.RVALID = 0;
            end
            stray_q = stray;
            aw_hs = bus.AWVALID && bus.AWREADY;
            if (aw_hs) aw_addr_s = bus.AWADDR;
            w_hs = bus.WVALID && bus.WREADY;
            if (w_hs) w_data_s = bus.WDATA;
            ar_hs = bus.ARVALID && bus.ARREADY;
            if (ar_hs) ar_addr_s = bus.ARADDR;
            b_hs = bus.BVALID && bus.BREADY;
            r_hs = bus.RVALID && bus.RREADY;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge ACLK);
         if (ARESETn && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
               check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

   initial begin : main
      int w;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1;
      aw_dly = 1; w_dly = 1; ar_dly = 0; b_dly = 0; r_dly = 1;
      bresp_cfg = 2'b00; rresp_cfg = 2'b00; ar_never = 0; stray = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;

      repeat (3) @(posedge ACLK);
      #1;
      check("rst_ctl", {24'd0, cmd_ready, rsp_valid, rsp_timeout, bus.AWVALID, bus.WVALID,
                        bus.BREADY, bus.ARVALID, bus.RREADY}, 32'd0);
      check("rst_awaddr", 32'(bus.AWADDR), 32'd0);
      check("rst_araddr", 32'(bus.ARADDR), 32'd0);
      check("rst_wdata", bus.WDATA, 32'd0);
      check("rst_rsp", {rsp_rdata[31:2], rsp_rdata[1:0] | rsp_resp}, 32'd0);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
      check("bready_idle", 32'(bus.BREADY | bus.RREADY), 32'd0);

      // Write 0xDEADBEEF to 0x3, both readies one cycle late.
      push_exp(32'd0, 2'b00, 1'b0);
      ref_mem[3] = 32'hDEADBEEF;
      send_cmd(1'b1, 4'h3, 32'hDEADBEEF, w);
      check("wr_valids_t1", {30'd0, bus.AWVALID, bus.WVALID}, 32'd3);
      check("wr_awaddr", 32'(bus.AWADDR), 32'h3);
      check("wr_wdata", bus.WDATA, 32'hDEADBEEF);
      @(posedge ACLK); #1;
      check("wr_valids_hold", {30'd0, bus.AWVALID, bus.WVALID}, 32'd3);
      @(posedge ACLK); #1;
      check("wr_valids_drop", {29'd0, bus.AWVALID, bus.WVALID, bus.BREADY}, 32'd1);
      wait_rsp(1);

      // Read it back, RVALID two cycles after AR.
      push_exp(ref_mem[3], 2'b00, 1'b0);
      send_cmd(1'b0, 4'h3, 32'd0, w);
      check("rd_arvalid", {27'd0, bus.ARVALID, bus.ARADDR}, 32'h13);
      wait_rsp(2);

      // W lags AW by three cycles; BRESP = EXOKAY.
      aw_dly = 0; w_dly = 3; bresp_cfg = 2'b01;
      push_exp(32'd0, 2'b01, 1'b0);
      ref_mem[9] = 32'hCAFE0009;
      send_cmd(1'b1, 4'h9, 32'hCAFE0009, w);
      check("wlag_valids_t1", {30'd0, bus.AWVALID, bus.WVALID}, 32'd3);
      for (int i = 1; i <= 3; i++) begin
         @(posedge ACLK); #1;
         check("wlag_w_hold", {29'd0, bus.AWVALID, bus.WVALID, bus.BREADY}, 32'd2);
      end
      @(posedge ACLK); #1;
      check("wlag_wresp", {29'd0, bus.AWVALID, bus.WVALID, bus.BREADY}, 32'd1);
      wait_rsp(3);
      aw_dly = 1; w_dly = 1; bresp_cfg = 2'b00;
      push_exp(ref_mem[9], 2'b00, 1'b0);
      send_cmd(1'b0, 4'h9, 32'd0, w);
      wait_rsp(4);

      // Read timeout with ARREADY never given, response then held for 5 cycles
      // while stray B/R valids are presented.
      rsp_ready = 0; ar_never = 1;
      push_exp(32'd0, 2'b10, 1'b1);
      send_cmd(1'b0, 4'h5, 32'd0, w);
      check("to_arvalid_0", 32'(bus.ARVALID), 32'd1);
      for (int i = 1; i <= 7; i++) begin
         @(posedge ACLK); #1;
         check("to_arvalid_hold", {30'd0, bus.ARVALID, rsp_valid}, 32'd2);
      end
      @(posedge ACLK); #1;
      check("to_fire", {29'd0, bus.ARVALID, bus.RREADY, rsp_valid}, 32'd1);
      stray = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge ACLK); #1;
         check("hold_rsp", {rsp_rdata[31:4], rsp_valid, rsp_timeout, rsp_resp}, 32'hE);
         check("hold_rdata_low", 32'(rsp_rdata[3:0]), 32'd0);
         check("hold_ready", {29'd0, cmd_ready, bus.BREADY, bus.RREADY}, 32'd0);
      end
      stray = 0; ar_never = 0; rsp_ready = 1;
      wait_rsp(5);
      push_exp(ref_mem[3], 2'b00, 1'b0);
      send_cmd(1'b0, 4'h3, 32'd0, w);
      check("cmd_immediate", 32'(w), 32'd0);
      wait_rsp(6);

      // AR handshake on the very cycle the counter hits the limit.
      ar_dly = 7; r_dly = 0;
      push_exp(ref_mem[9], 2'b00, 1'b0);
      send_cmd(1'b0, 4'h9, 32'd0, w);
      wait_rsp(7);
      ar_dly = 0; r_dly = 1;

      // Reset pulse while waiting in WRESP aborts the write silently.
      b_dly = 6;
      send_cmd(1'b1, 4'h7, 32'h5555AAAA, w);
      for (int i = 0; i < 20 && !bus.BREADY; i++) begin
         @(posedge ACLK); #1;
      end
      check("abort_bready_seen", 32'(bus.BREADY), 32'd1);
      #2 ARESETn = 1'b0;
      #1;
      check("abort_async", {24'd0, cmd_ready, rsp_valid, rsp_timeout, bus.AWVALID, bus.WVALID,
                            bus.BREADY, bus.ARVALID, bus.RREADY}, 32'd0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      check("abort_cmd_ready", {30'd0, cmd_ready, rsp_valid}, 32'd2);
      b_dly = 0;
      repeat (3) @(posedge ACLK);
      #1;
      check("abort_no_rsp", 32'(n_rsp), 32'd7);
      push_exp(ref_mem[3], 2'b00, 1'b0);
      send_cmd(1'b0, 4'h3, 32'd0, w);
      wait_rsp(8);

      repeat (5) @(posedge ACLK);
      #1;
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
